// File: rtl/ob_pkg.sv
// Shared types for the order-book engine: opcodes, response statuses,
// command/response records and the resting-entry layout used by both book sides.
package ob_pkg;

  localparam int UID_W   = 32;
  localparam int PRICE_W = 16;
  localparam int QTY_W   = 16;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_BUY     = 3'd1,
    OP_SELL    = 3'd2,
    OP_CANCEL  = 3'd3,
    OP_QRY_BID = 3'd4,
    OP_QRY_ASK = 3'd5
  } opcode_t;

  typedef enum logic [3:0] {
    ST_TRADE       = 4'd0,
    ST_FILLED      = 4'd1,
    ST_RESTED      = 4'd2,
    ST_REJECT_BAD  = 4'd3,
    ST_REJECT_FULL = 4'd4,
    ST_CANCEL_HIT  = 4'd5,
    ST_CANCEL_MISS = 4'd6,
    ST_QRY_HIT     = 4'd7,
    ST_QRY_EMPTY   = 4'd8
  } status_t;

  typedef struct packed {
    opcode_t            opcode;
    logic [UID_W-1:0]   uid;
    logic [PRICE_W-1:0] price;
    logic [QTY_W-1:0]   qty;
  } cmd_t;

  typedef struct packed {
    status_t            status;
    logic [UID_W-1:0]   uid;
    logic [UID_W-1:0]   uid_maker;
    logic [PRICE_W-1:0] price;
    logic [QTY_W-1:0]   qty;
  } rsp_t;

  typedef struct packed {
    logic [UID_W-1:0]   uid;
    logic [PRICE_W-1:0] price;
    logic [QTY_W-1:0]   qty;
  } entry_t;

endpackage

// File: rtl/ob_table.sv
// One price/time-sorted side of the book. Index 0 is the best entry; at most
// one of insert, remove-by-index or head-quantity-decrement acts per cycle.
module ob_table
  import ob_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter bit ASCENDING = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ins_i,
  input  entry_t                   ins_e_i,
  input  logic                     rm_i,
  input  logic [$clog2(DEPTH)-1:0] rm_idx_i,
  input  logic                     dec_i,
  input  logic [QTY_W-1:0]         dec_qty_i,
  input  logic [UID_W-1:0]         find_uid_i,
  output entry_t                   head_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic                     find_hit_o,
  output logic [$clog2(DEPTH)-1:0] find_idx_o,
  output entry_t                   find_e_o
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  int               ins_pos;

  // True when price a must sit ahead of an existing entry at price b.
  function automatic logic goes_before(input logic [PRICE_W-1:0] a,
                                       input logic [PRICE_W-1:0] b);
    return ASCENDING ? (a < b) : (a > b);
  endfunction

  assign head_o  = ent_q[0];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (int'(cnt_q) == DEPTH);

  // New order lands after every entry of equal price, keeping time priority.
  always_comb begin
    ins_pos = int'(cnt_q);
    for (int i = DEPTH - 1; i >= 0; i--)
      if (i < int'(cnt_q) && goes_before(ins_e_i.price, ent_q[i].price)) ins_pos = i;
  end

  always_comb begin
    ent_d = ent_q;
    cnt_d = cnt_q;
    if (ins_i && !full_o) begin
      for (int i = 1; i < DEPTH; i++)
        if (i > ins_pos) ent_d[i] = ent_q[i-1];
      for (int i = 0; i < DEPTH; i++)
        if (i == ins_pos) ent_d[i] = ins_e_i;
      cnt_d = cnt_q + 1'b1;
    end else if (rm_i) begin
      for (int i = 0; i < DEPTH - 1; i++)
        if (i >= int'(rm_idx_i)) ent_d[i] = ent_q[i+1];
      cnt_d = cnt_q - 1'b1;
    end else if (dec_i) begin
      ent_d[0].qty = ent_q[0].qty - dec_qty_i;
    end
  end

  // Lowest-index live entry with the requested uid wins.
  always_comb begin
    find_hit_o = 1'b0;
    find_idx_o = '0;
    find_e_o   = ent_q[0];
    for (int i = DEPTH - 1; i >= 0; i--)
      if (i < int'(cnt_q) && ent_q[i].uid == find_uid_i) begin
        find_hit_o = 1'b1;
        find_idx_o = IDX_W'(i);
        find_e_o   = ent_q[i];
      end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

endmodule

// File: rtl/ob_engine_p.sv
// Order-book engine: command FIFO with one skid slot, a single-command FSM and
// two sorted book sides; emits one response per fill plus one terminal response.
module ob_engine_p
  import ob_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int FIFO_N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_vld_r,
  input  cmd_t cmd_r,
  output logic cmd_full_r,
  input  logic rsp_accept,
  output logic rsp_vld,
  output rsp_t rsp
);
  localparam int PTR_W = $clog2(FIFO_N);
  localparam int CNT_W = $clog2(FIFO_N + 1);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_MATCH, S_CANCEL, S_QUERY, S_REJECT, S_EMIT
  } state_t;

  state_t           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  rsp_t             rsp_q, rsp_d;
  logic             rsp_vld_q, rsp_vld_d;
  logic             ret_q, ret_d;

  cmd_t             fifo_mem [FIFO_N];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic             full_q, push, pop;

  entry_t           bid_head, ask_head, bid_find_e, ask_find_e, ins_e, opp_head;
  logic             bid_empty, ask_empty, bid_full, ask_full, bid_hit, ask_hit;
  logic [IDX_W-1:0] bid_idx, ask_idx, rm_idx;
  logic             bid_ins, ask_ins, bid_rm, ask_rm, bid_dec, ask_dec;
  logic [QTY_W-1:0] dec_qty, fill;
  logic             is_buy, opp_empty, own_full, crosses;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == FIFO_N - 1) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [QTY_W-1:0] min_qty(input logic [QTY_W-1:0] a,
                                               input logic [QTY_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic rsp_t mk_rsp(input status_t st, input logic [UID_W-1:0] uid,
                                  input logic [UID_W-1:0] maker,
                                  input logic [PRICE_W-1:0] price,
                                  input logic [QTY_W-1:0] qty);
    rsp_t r;
    r.status    = st;
    r.uid       = uid;
    r.uid_maker = maker;
    r.price     = price;
    r.qty       = qty;
    return r;
  endfunction

  assign cmd_full_r = full_q;
  assign rsp_vld    = rsp_vld_q;
  assign rsp        = rsp_q;

  // Ingress FIFO; the reserved slot absorbs the command already in flight upstream.
  assign pop  = (state_q == S_IDLE) && (fifo_cnt_q != '0);
  assign push = cmd_vld_r && ((int'(fifo_cnt_q) < FIFO_N) || pop);

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + 1'b1;
    else if (pop && !push) fifo_cnt_d = fifo_cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      full_q     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      fifo_cnt_q <= fifo_cnt_d;
      full_q     <= (int'(fifo_cnt_d) >= FIFO_N - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= cmd_r;
  end

  ob_table #(.DEPTH(DEPTH), .ASCENDING(1'b0)) u_bid (
    .clk(clk), .rst(rst),
    .ins_i(bid_ins), .ins_e_i(ins_e),
    .rm_i(bid_rm), .rm_idx_i(rm_idx),
    .dec_i(bid_dec), .dec_qty_i(dec_qty),
    .find_uid_i(cmd_q.uid),
    .head_o(bid_head), .empty_o(bid_empty), .full_o(bid_full),
    .find_hit_o(bid_hit), .find_idx_o(bid_idx), .find_e_o(bid_find_e)
  );

  ob_table #(.DEPTH(DEPTH), .ASCENDING(1'b1)) u_ask (
    .clk(clk), .rst(rst),
    .ins_i(ask_ins), .ins_e_i(ins_e),
    .rm_i(ask_rm), .rm_idx_i(rm_idx),
    .dec_i(ask_dec), .dec_qty_i(dec_qty),
    .find_uid_i(cmd_q.uid),
    .head_o(ask_head), .empty_o(ask_empty), .full_o(ask_full),
    .find_hit_o(ask_hit), .find_idx_o(ask_idx), .find_e_o(ask_find_e)
  );

  // A BUY trades against the ask head, a SELL against the bid head.
  assign is_buy    = (cmd_q.opcode == OP_BUY);
  assign opp_head  = is_buy ? ask_head : bid_head;
  assign opp_empty = is_buy ? ask_empty : bid_empty;
  assign own_full  = is_buy ? bid_full : ask_full;
  assign crosses   = is_buy ? (cmd_q.price >= opp_head.price) : (cmd_q.price <= opp_head.price);
  assign fill      = min_qty(cmd_q.qty, opp_head.qty);

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    rsp_d     = rsp_q;
    rsp_vld_d = rsp_vld_q;
    ret_d     = ret_q;
    bid_ins   = 1'b0;
    ask_ins   = 1'b0;
    bid_rm    = 1'b0;
    ask_rm    = 1'b0;
    bid_dec   = 1'b0;
    ask_dec   = 1'b0;
    rm_idx    = '0;
    dec_qty   = fill;
    ins_e.uid   = cmd_q.uid;
    ins_e.price = cmd_q.price;
    ins_e.qty   = cmd_q.qty;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          cmd_d   = fifo_mem[rd_ptr_q];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (cmd_q.opcode)
          OP_NOP:                state_d = S_IDLE;
          OP_BUY, OP_SELL:       state_d = (cmd_q.price == '0 || cmd_q.qty == '0) ? S_REJECT : S_MATCH;
          OP_CANCEL:             state_d = S_CANCEL;
          OP_QRY_BID, OP_QRY_ASK: state_d = S_QUERY;
          default:               state_d = S_REJECT;
        endcase
      end
      S_MATCH: begin
        rsp_vld_d = 1'b1;
        state_d   = S_EMIT;
        ret_d     = 1'b0;
        if (cmd_q.qty != '0 && !opp_empty && crosses) begin
          rsp_d     = mk_rsp(ST_TRADE, cmd_q.uid, opp_head.uid, opp_head.price, fill);
          cmd_d.qty = cmd_q.qty - fill;
          ret_d     = 1'b1;
          if (opp_head.qty == fill) begin
            bid_rm = !is_buy;
            ask_rm = is_buy;
          end else begin
            bid_dec = !is_buy;
            ask_dec = is_buy;
          end
        end else if (cmd_q.qty == '0) begin
          rsp_d = mk_rsp(ST_FILLED, cmd_q.uid, '0, cmd_q.price, '0);
        end else if (!own_full) begin
          rsp_d   = mk_rsp(ST_RESTED, cmd_q.uid, '0, cmd_q.price, cmd_q.qty);
          bid_ins = is_buy;
          ask_ins = !is_buy;
        end else begin
          rsp_d = mk_rsp(ST_REJECT_FULL, cmd_q.uid, '0, cmd_q.price, cmd_q.qty);
        end
      end
      S_CANCEL: begin
        rsp_vld_d = 1'b1;
        state_d   = S_EMIT;
        ret_d     = 1'b0;
        if (bid_hit) begin
          rsp_d  = mk_rsp(ST_CANCEL_HIT, bid_find_e.uid, '0, bid_find_e.price, bid_find_e.qty);
          bid_rm = 1'b1;
          rm_idx = bid_idx;
        end else if (ask_hit) begin
          rsp_d  = mk_rsp(ST_CANCEL_HIT, ask_find_e.uid, '0, ask_find_e.price, ask_find_e.qty);
          ask_rm = 1'b1;
          rm_idx = ask_idx;
        end else begin
          rsp_d = mk_rsp(ST_CANCEL_MISS, cmd_q.uid, '0, '0, '0);
        end
      end
      S_QUERY: begin
        rsp_vld_d = 1'b1;
        state_d   = S_EMIT;
        ret_d     = 1'b0;
        if (cmd_q.opcode == OP_QRY_BID)
          rsp_d = bid_empty ? mk_rsp(ST_QRY_EMPTY, cmd_q.uid, '0, '0, '0)
                            : mk_rsp(ST_QRY_HIT, bid_head.uid, '0, bid_head.price, bid_head.qty);
        else
          rsp_d = ask_empty ? mk_rsp(ST_QRY_EMPTY, cmd_q.uid, '0, '0, '0)
                            : mk_rsp(ST_QRY_HIT, ask_head.uid, '0, ask_head.price, ask_head.qty);
      end
      S_REJECT: begin
        rsp_vld_d = 1'b1;
        state_d   = S_EMIT;
        ret_d     = 1'b0;
        rsp_d     = mk_rsp(ST_REJECT_BAD, cmd_q.uid, '0, cmd_q.price, cmd_q.qty);
      end
      S_EMIT: begin
        if (rsp_accept) begin
          rsp_vld_d = 1'b0;
          state_d   = ret_q ? S_MATCH : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rsp_vld_q <= 1'b0;
      ret_q     <= 1'b0;
      rsp_q     <= '0;
    end else begin
      state_q   <= state_d;
      rsp_vld_q <= rsp_vld_d;
      ret_q     <= ret_d;
      rsp_q     <= rsp_d;
    end
  end

  always_ff @(posedge clk) begin
    cmd_q <= cmd_d;
  end

endmodule
